// File: rtl/osecpu_pkg.sv
// Shared OSECPU definitions: opcode constants, fetch/decode state encoding,
// opcode classes and register-index width.
package osecpu_pkg;

    localparam int               REG_IDX_W  = 6;
    localparam logic [REG_IDX_W-1:0] REG_RW_RST = 6'h3F;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_LIMM      = 8'h02;
    localparam logic [7:0] OP_JMP       = 8'h03;
    localparam logic [7:0] OP_ALU_FIRST = 8'h10;
    localparam logic [7:0] OP_ALU_LAST  = 8'h1B;
    localparam logic [7:0] OP_HALT      = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_ISSUE,
        ST_HALT
    } fd_state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LIMM,
        CLS_JMP,
        CLS_ALU,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/fd_field_decode.sv
// Combinational field extraction and opcode classification for fetch_decode.
// FETCH_DECODE_JUMP_EN: when defined, opcode 0x03 is classified as JMP; otherwise it is illegal.
module fd_field_decode
    import osecpu_pkg::*;
(
    input  logic [31:6]          i_word,
    output logic [3:0]           o_alu_op,
    output logic [REG_IDX_W-1:0] o_rw,
    output logic [REG_IDX_W-1:0] o_r0,
    output logic [REG_IDX_W-1:0] o_r1,
    output op_class_t            o_class
);

    logic [7:0] w_opcode;

    assign w_opcode = i_word[31:24];
    assign o_alu_op = i_word[27:24];
    assign o_rw     = i_word[23:18];
    assign o_r0     = i_word[17:12];
    assign o_r1     = i_word[11:6];

    always_comb begin
        o_class = CLS_ILLEGAL;
        if (w_opcode == OP_NOP)
            o_class = CLS_NOP;
        else if (w_opcode == OP_LIMM)
            o_class = CLS_LIMM;
`ifdef FETCH_DECODE_JUMP_EN
        else if (w_opcode == OP_JMP)
            o_class = CLS_JMP;
`endif
        else if (w_opcode >= OP_ALU_FIRST && w_opcode <= OP_ALU_LAST)
            o_class = CLS_ALU;
        else if (w_opcode == OP_HALT)
            o_class = CLS_HALT;
    end

endmodule

// File: rtl/fetch_decode.sv
// OSECPU instruction fetch/decode stage: walks a synchronous-read ROM and issues
// decoded instructions over a valid/stall handshake. JMP support via FETCH_DECODE_JUMP_EN.
module fetch_decode
    import osecpu_pkg::*;
#(
    parameter int PC_WIDTH = 10
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic [PC_WIDTH-1:0]  rom_addr,
    input  logic [31:0]          rom_data,
    input  logic                 stall,
    output logic                 valid,
    output logic [REG_IDX_W-1:0] ireg_r0,
    output logic [REG_IDX_W-1:0] ireg_r1,
    output logic [REG_IDX_W-1:0] ireg_rw,
    output logic                 ireg_we,
    output logic [3:0]           alu_op,
    output logic [31:0]          imm,
    output logic                 imm_sel,
    output logic                 halted,
    output logic                 err
);

    fd_state_t            r_state;
    fd_state_t            w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc;
    logic                 r_valid;
    logic [REG_IDX_W-1:0] r_r0;
    logic [REG_IDX_W-1:0] r_r1;
    logic [REG_IDX_W-1:0] r_rw;
    logic                 r_we;
    logic [3:0]           r_alu_op;
    logic [31:0]          r_imm;
    logic                 r_imm_sel;
    logic                 r_halted;
    logic                 r_err;

    logic [3:0]           w_alu_op;
    logic [REG_IDX_W-1:0] w_rw;
    logic [REG_IDX_W-1:0] w_r0;
    logic [REG_IDX_W-1:0] w_r1;
    op_class_t            w_class;
    logic                 w_unused_lo;

    // Low word bits carry no field; they only matter as a jump target.
    assign w_unused_lo = ^rom_data[5:0];

    fd_field_decode u_field_decode (
        .i_word   (rom_data[31:6]),
        .o_alu_op (w_alu_op),
        .o_rw     (w_rw),
        .o_r0     (w_r0),
        .o_r1     (w_r1),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
            ST_FETCH:  w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_NOP:  w_state_nxt = ST_FETCH;
                    CLS_LIMM: w_state_nxt = ST_IMM;
                    CLS_JMP:  w_state_nxt = ST_FETCH;
                    CLS_ALU:  w_state_nxt = ST_ISSUE;
                    default:  w_state_nxt = ST_HALT;
                endcase
            end
            ST_IMM:    w_state_nxt = ST_ISSUE;
            ST_ISSUE:  if (!stall) w_state_nxt = ST_FETCH;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // pc and all issued fields; ISSUE with stall=1 leaves everything untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_valid   <= 1'b0;
            r_r0      <= '0;
            r_r1      <= '0;
            r_rw      <= REG_RW_RST;
            r_we      <= 1'b0;
            r_alu_op  <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: r_pc <= r_pc + PC_WIDTH'(1);
                ST_DECODE: begin
                    case (w_class)
                        CLS_ALU: begin
                            r_rw      <= w_rw;
                            r_r0      <= w_r0;
                            r_r1      <= w_r1;
                            r_alu_op  <= w_alu_op;
                            r_we      <= 1'b1;
                            r_imm_sel <= 1'b0;
                            r_valid   <= 1'b1;
                        end
                        CLS_LIMM: r_rw <= w_rw;
                        CLS_JMP:  r_pc <= rom_data[PC_WIDTH-1:0];
                        CLS_HALT: r_halted <= 1'b1;
                        CLS_ILLEGAL: begin
                            r_halted <= 1'b1;
                            r_err    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_IMM: begin
                    r_imm     <= rom_data;
                    r_pc      <= r_pc + PC_WIDTH'(1);
                    r_we      <= 1'b1;
                    r_imm_sel <= 1'b1;
                    r_valid   <= 1'b1;
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        r_we    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign valid    = r_valid;
    assign ireg_r0  = r_r0;
    assign ireg_r1  = r_r1;
    assign ireg_rw  = r_rw;
    assign ireg_we  = r_we;
    assign alu_op   = r_alu_op;
    assign imm      = r_imm;
    assign imm_sel  = r_imm_sel;
    assign halted   = r_halted;
    assign err      = r_err;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode: a 10-bit main instance plus a
// PC_WIDTH=2 instance for the pc wrap scenario.
module tb_fetch_decode;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, stall;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        valid, ireg_we, imm_sel, halted, err;
    logic [5:0]  ireg_r0, ireg_r1, ireg_rw;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] rom [0:1023];

    logic        reset2, run2, stall2;
    logic [1:0]  rom_addr2;
    logic [31:0] rom_data2;
    logic        valid2, ireg_we2, imm_sel2, halted2, err2;
    logic [5:0]  ireg_r02, ireg_r12, ireg_rw2;
    logic [3:0]  alu_op2;
    logic [31:0] imm2;
    logic [31:0] rom2 [0:3];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode #(.PC_WIDTH(10)) u_dut (
        .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .stall(stall), .valid(valid), .ireg_r0(ireg_r0), .ireg_r1(ireg_r1),
        .ireg_rw(ireg_rw), .ireg_we(ireg_we), .alu_op(alu_op), .imm(imm),
        .imm_sel(imm_sel), .halted(halted), .err(err)
    );

    fetch_decode #(.PC_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset2), .run(run2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .stall(stall2), .valid(valid2), .ireg_r0(ireg_r02), .ireg_r1(ireg_r12),
        .ireg_rw(ireg_rw2), .ireg_we(ireg_we2), .alu_op(alu_op2), .imm(imm2),
        .imm_sel(imm_sel2), .halted(halted2), .err(err2)
    );

    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= rom2[rom_addr2];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hFF00_0000;
    endtask

    task automatic do_reset;
        reset = 1'b1; run = 1'b0; stall = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic pulse_run;
        run = 1'b1;
        tick(1);
        run = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b0; stall = 1'b0;
        tick(2);
        reset = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || ireg_we !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid/we/halted/err=%b%b%b%b want 0000", valid, ireg_we, halted, err);
        end
        n_checks++;
        if (ireg_rw !== 6'h3F || ireg_r0 !== 6'd0 || ireg_r1 !== 6'd0 || alu_op !== 4'd0 ||
            imm !== 32'd0 || imm_sel !== 1'b0 || rom_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_fields: rw=%h r0=%h r1=%h op=%h imm=%h sel=%b pc=%0d want 3f 0 0 0 0 0 0",
                     ireg_rw, ireg_r0, ireg_r1, alu_op, imm, imm_sel, rom_addr);
        end
        tick(3);
        n_checks++;
        if (rom_addr !== 10'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: pc=%0d valid=%b want 0 0", rom_addr, valid);
        end
    endtask

    task automatic test_limm;
        clear_rom();
        rom[0] = 32'h020C_0000;
        rom[1] = 32'h0000_1234;
        do_reset();
        pulse_run();
        tick(2);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL limm_early_valid: got %b want 0", valid);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b1 || ireg_rw !== 6'd3 || imm !== 32'h1234 || imm_sel !== 1'b1 || ireg_we !== 1'b1) begin
            n_fail++;
            $display("FAIL limm_issue: valid=%b rw=%0d imm=%h sel=%b we=%b want 1 3 00001234 1 1",
                     valid, ireg_rw, imm, imm_sel, ireg_we);
        end
        n_checks++;
        if (rom_addr !== 10'd2) begin
            n_fail++;
            $display("FAIL limm_pc: got %0d want 2", rom_addr);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL limm_consume: valid=%b want 0", valid);
        end
    endtask

    task automatic test_stall;
        clear_rom();
        rom[0] = 32'h1408_50C0;
        do_reset();
        stall = 1'b1;
        pulse_run();
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_decode_valid: got %b want 0", valid);
        end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick(1);
            else tick(1);
            n_checks++;
            if ({valid, ireg_rw, ireg_r0, ireg_r1, alu_op, ireg_we, imm_sel} !==
                {1'b1, 6'd2, 6'd5, 6'd3, 4'd4, 1'b1, 1'b0} || rom_addr !== 10'd1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b rw=%0d r0=%0d r1=%0d op=%h we=%b sel=%b pc=%0d want 1 2 5 3 4 1 0 1",
                         c, valid, ireg_rw, ireg_r0, ireg_r1, alu_op, ireg_we, imm_sel, rom_addr);
            end
        end
        stall = 1'b0;
        tick(1);
        n_checks++;
        if (valid !== 1'b0 || rom_addr !== 10'd1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b pc=%0d want 0 1", valid, rom_addr);
        end
        tick(1);
        n_checks++;
        if (rom_addr !== 10'd2) begin
            n_fail++;
            $display("FAIL stall_next_fetch: pc=%0d want 2", rom_addr);
        end
    endtask

    task automatic test_back_to_back;
        clear_rom();
        rom[0] = 32'h1008_50C0;
        rom[1] = 32'h1B29_4780;
        do_reset();
        pulse_run();
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || ireg_rw !== 6'd2 || alu_op !== 4'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b rw=%0d op=%h err=%b want 1 2 0 0", valid, ireg_rw, alu_op, err);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap_fetch: valid=%b want 0", valid);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap_decode: valid=%b want 0", valid);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b1 || ireg_rw !== 6'd10 || ireg_r0 !== 6'd20 || ireg_r1 !== 6'd30 || alu_op !== 4'hB) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b rw=%0d r0=%0d r1=%0d op=%h want 1 10 20 30 b",
                     valid, ireg_rw, ireg_r0, ireg_r1, alu_op);
        end
        tick(1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b want 0", valid);
        end
    endtask

    task automatic test_nop_halt;
        int seen_valid;
        clear_rom();
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h0000_0000;
        do_reset();
        pulse_run();
        seen_valid = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (valid !== 1'b0 || halted !== 1'b0) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL nop_quiet: %0d cycles with valid or halted set, want 0", seen_valid);
        end
        tick(1);
        n_checks++;
        if (halted !== 1'b1 || err !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_halt: halted=%b err=%b valid=%b want 1 0 0", halted, err, valid);
        end
        pulse_run();
        tick(3);
        n_checks++;
        if (halted !== 1'b1 || valid !== 1'b0 || rom_addr !== 10'd3) begin
            n_fail++;
            $display("FAIL halt_ignores_run: halted=%b valid=%b pc=%0d want 1 0 3", halted, valid, rom_addr);
        end
    endtask

    task automatic test_illegal;
        logic [7:0] ops [4];
        ops[0] = 8'h7E; ops[1] = 8'h1C; ops[2] = 8'h01; ops[3] = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            clear_rom();
            rom[0] = {ops[k], 24'h0};
            do_reset();
            pulse_run();
            tick(1);
            n_checks++;
            if (halted !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%h_early: halted=%b want 0", ops[k], halted);
            end
            tick(1);
            n_checks++;
            if (halted !== 1'b1 || err !== 1'b1 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_%h: halted=%b err=%b valid=%b want 1 1 0", ops[k], halted, err, valid);
            end
        end
    endtask

    task automatic test_jmp;
        clear_rom();
        rom[0] = 32'h0300_0005;
        rom[5] = 32'h1408_50C0;
        do_reset();
        pulse_run();
        tick(2);
`ifdef FETCH_DECODE_JUMP_EN
        n_checks++;
        if (halted !== 1'b0 || rom_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL jmp_target: halted=%b pc=%0d want 0 5", halted, rom_addr);
        end
        tick(2);
        n_checks++;
        if (valid !== 1'b1 || ireg_rw !== 6'd2) begin
            n_fail++;
            $display("FAIL jmp_issue: valid=%b rw=%0d want 1 2", valid, ireg_rw);
        end
`else
        n_checks++;
        if (halted !== 1'b1 || err !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_illegal: halted=%b err=%b valid=%b want 1 1 0", halted, err, valid);
        end
`endif
    endtask

    task automatic test_reset_in_issue;
        clear_rom();
        rom[0] = 32'h1408_50C0;
        do_reset();
        stall = 1'b1;
        pulse_run();
        tick(2);
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_issue_pre: valid=%b want 1", valid);
        end
        reset = 1'b1; run = 1'b1;
        tick(1);
        reset = 1'b0; run = 1'b0; stall = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || ireg_rw !== 6'h3F || rom_addr !== 10'd0 || ireg_we !== 1'b0 ||
            ireg_r0 !== 6'd0 || ireg_r1 !== 6'd0 || alu_op !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_issue: valid=%b rw=%h pc=%0d we=%b r0=%0d r1=%0d op=%h want 0 3f 0 0 0 0 0",
                     valid, ireg_rw, rom_addr, ireg_we, ireg_r0, ireg_r1, alu_op);
        end
        tick(3);
        n_checks++;
        if (rom_addr !== 10'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_issue_idle: pc=%0d valid=%b want 0 0", rom_addr, valid);
        end
    endtask

    task automatic test_wrap;
        rom2[0] = 32'h0000_0000;
        rom2[1] = 32'h0000_0000;
        rom2[2] = 32'h0000_0000;
        rom2[3] = 32'h1408_50C0;
        reset2 = 1'b1; run2 = 1'b0; stall2 = 1'b0;
        tick(1);
        reset2 = 1'b0; run2 = 1'b1;
        tick(1);
        run2 = 1'b0;
        tick(6);
        n_checks++;
        if (rom_addr2 !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_pc3: pc=%0d want 3", rom_addr2);
        end
        rom2[0] = 32'hFF00_0000;
        tick(1);
        n_checks++;
        if (rom_addr2 !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_pc0: pc=%0d want 0", rom_addr2);
        end
        tick(1);
        n_checks++;
        if (valid2 !== 1'b1 || ireg_rw2 !== 6'd2 || alu_op2 !== 4'd4) begin
            n_fail++;
            $display("FAIL wrap_issue: valid=%b rw=%0d op=%h want 1 2 4", valid2, ireg_rw2, alu_op2);
        end
        tick(3);
        n_checks++;
        if (halted2 !== 1'b1 || err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_halt: halted=%b err=%b want 1 0", halted2, err2);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; stall = 1'b0;
        reset2 = 1'b1; run2 = 1'b0; stall2 = 1'b0;
        clear_rom();
        for (int i = 0; i < 4; i++) rom2[i] = 32'hFF00_0000;
        test_reset();
        test_limm();
        test_stall();
        test_back_to_back();
        test_nop_halt();
        test_illegal();
        test_jmp();
        test_reset_in_issue();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
